// File: rtl/if_unit.sv
// Instruction fetch unit: pc sequencing, in-order memory requests, 2-entry instruction FIFO, jump redirect with drain.
// Build option IF_UNIT_BYPASS_EN forwards a response straight to the output when the FIFO is empty.
module if_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_FETCH = 2'd1;
    localparam logic [1:0]  ST_DRAIN = 2'd2;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fifoInst [2];
    logic [31:0] r_fifoAddr [2];
    logic        r_rdPtr;
    logic        r_wrPtr;
    logic [1:0]  r_count;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_discard;

    logic [1:0]  w_stateNext;
    logic [1:0]  w_outNext;
    logic [1:0]  w_discardNext;
    logic [2:0]  w_inFlight;
    logic [31:0] w_rspAddr;
    logic        w_fifoEmpty;
    logic        w_grant;
    logic        w_rsp;
    logic        w_accept;
    logic        w_bypass;
    logic        w_push;
    logic        w_pop;

    assign w_fifoEmpty = (r_count == 2'd0);
    assign w_inFlight  = {1'b0, r_count} + {1'b0, r_outstanding};

    // Credit check: every granted request must have a FIFO slot waiting for its response.
    assign mem_req_o  = !rst && (r_state == ST_FETCH) && !hold_i && !jump_en_i && (w_inFlight < 3'd2);
    assign mem_addr_o = r_pc;
    assign w_grant    = mem_req_o && mem_gnt_i;
    assign w_rsp      = mem_rvalid_i && (r_outstanding != 2'd0);

    // Responses return in order, so the oldest outstanding request sits 4*outstanding bytes behind pc.
    assign w_rspAddr = r_pc - {28'd0, r_outstanding, 2'b00};
    assign w_accept  = w_rsp && (r_state != ST_DRAIN) && !jump_en_i && !rst;

`ifdef IF_UNIT_BYPASS_EN
    assign w_bypass = w_accept && w_fifoEmpty && !hold_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign inst_valid_o = !rst && !hold_i && (!w_fifoEmpty || w_bypass);
    assign w_pop        = inst_valid_o && inst_ready_i && !w_fifoEmpty && !jump_en_i;
    assign w_push       = w_accept && !(w_bypass && inst_ready_i);
    assign w_outNext    = r_outstanding + {1'b0, w_grant} - {1'b0, w_rsp};

    always_comb begin
        inst_o      = NOP_INST;
        inst_addr_o = r_pc;
        if (rst) begin
            inst_addr_o = RESET_PC;
        end else if (!w_fifoEmpty) begin
            inst_o      = r_fifoInst[r_rdPtr];
            inst_addr_o = r_fifoAddr[r_rdPtr];
        end else if (w_bypass) begin
            inst_o      = mem_rdata_i;
            inst_addr_o = w_rspAddr;
        end
    end

    // Responses that belong to the abandoned stream are counted off before fetching resumes.
    always_comb begin
        w_discardNext = r_discard;
        if (r_state == ST_DRAIN) begin
            if (w_rsp && (r_discard != 2'd0)) begin
                w_discardNext = r_discard - 2'd1;
            end
        end else if (jump_en_i) begin
            w_discardNext = w_outNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:  w_stateNext = ST_FETCH;
            ST_FETCH: if (jump_en_i && (w_outNext != 2'd0)) w_stateNext = ST_DRAIN;
            ST_DRAIN: if (!jump_en_i && (w_discardNext == 2'd0)) w_stateNext = ST_FETCH;
            default:  w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_rdPtr       <= 1'b0;
            r_wrPtr       <= 1'b0;
            r_count       <= 2'd0;
            r_outstanding <= 2'd0;
            r_discard     <= 2'd0;
        end else begin
            r_state       <= w_stateNext;
            r_outstanding <= w_outNext;
            r_discard     <= w_discardNext;
            if (jump_en_i) begin
                r_pc <= jump_addr_i & ~32'h3;
            end else if (w_grant) begin
                r_pc <= r_pc + 32'd4;
            end
            if (jump_en_i) begin
                r_rdPtr <= 1'b0;
                r_wrPtr <= 1'b0;
                r_count <= 2'd0;
            end else begin
                if (w_push) r_wrPtr <= ~r_wrPtr;
                if (w_pop)  r_rdPtr <= ~r_rdPtr;
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoInst[r_wrPtr] <= mem_rdata_i;
            r_fifoAddr[r_wrPtr] <= w_rspAddr;
        end
    end

endmodule

// File: tb/tb_if_unit.sv
// Testbench for if_unit: directed scenarios plus randomized traffic against a transaction-level model
// (expected fetch pc, expected delivered address stream, in-order memory with per-address data).
module tb_if_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
`ifdef IF_UNIT_BYPASS_EN
    localparam logic [31:0] EXP_BYPASS = 32'd1;
`else
    localparam logic [31:0] EXP_BYPASS = 32'd0;
`endif

    logic        clk;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i;

    if_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .hold_i       (hold_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_ready_i (inst_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memRsp_t;

    memRsp_t     memQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cycleNum = 0;
    int          consumed = 0;
    int          grants = 0;
    int          tbOut = 0;
    int          discardPending = 0;
    logic [31:0] modelPc = RESET_PC;
    logic [31:0] expAddr = RESET_PC;
    logic [31:0] specialAddr = 32'hFFFF_FFFF;
    logic [31:0] staleData = 32'h0;
    bit          injectStale = 1'b0;
    bit          cycGrant;
    bit          cycConsume;
    bit          cycRsp;

    function automatic logic [31:0] memData(input logic [31:0] a);
        if (a == specialAddr) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, let the memory model answer, check outputs, advance the model.
    task automatic applyStimulus(input bit jmp, input logic [31:0] ja, input bit hld, input bit rdy,
                                 input bit gnt, input int lat);
        @(negedge clk);
        jump_en_i    = jmp;
        jump_addr_i  = ja;
        hold_i       = hld;
        inst_ready_i = rdy;
        mem_gnt_i    = gnt;
        cycRsp       = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom();
        if (injectStale) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = staleData;
            injectStale  = 1'b0;
        end else if (memQ.size() > 0 && memQ[0].due <= cycleNum) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = memData(memQ[0].addr);
            cycRsp       = 1'b1;
        end
        #1;
        if (hld || jmp || discardPending > 0 || tbOut >= 2) checkOutput("reqBlocked", 32'(mem_req_o), 32'd0);
        if (hld) checkOutput("validHold", 32'(inst_valid_o), 32'd0);
        cycGrant   = mem_req_o && gnt;
        cycConsume = inst_valid_o && rdy && !hld && !jmp;
        if (cycGrant) begin
            checkOutput("reqAddr", mem_addr_o, modelPc);
            memQ.push_back('{addr: modelPc, due: cycleNum + lat});
            modelPc += 32'd4;
            grants++;
        end
        if (cycConsume) begin
            checkOutput("instAddr", inst_addr_o, expAddr);
            checkOutput("instData", inst_o, memData(expAddr));
            expAddr += 32'd4;
            consumed++;
        end
        if (cycRsp) void'(memQ.pop_front());
        if (discardPending > 0) begin
            if (cycRsp) discardPending--;
        end else if (jmp) begin
            discardPending = tbOut - int'(cycRsp);
        end
        tbOut = tbOut + int'(cycGrant) - int'(cycRsp);
        if (jmp) begin
            modelPc = ja & ~32'h3;
            expAddr = ja & ~32'h3;
        end
        cycleNum++;
    endtask

    task automatic applyReset(input bit withStale);
        @(negedge clk);
        rst          = 1'b1;
        jump_en_i    = 1'b0;
        hold_i       = 1'b0;
        inst_ready_i = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        if (withStale && memQ.size() > 0) begin
            staleData   = memData(memQ[0].addr);
            injectStale = 1'b1;
        end
        memQ.delete();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rstReq", 32'(mem_req_o), 32'd0);
        checkOutput("rstValid", 32'(inst_valid_o), 32'd0);
        checkOutput("rstInst", inst_o, NOP_INST);
        checkOutput("rstAddr", inst_addr_o, RESET_PC);
        rst = 1'b0;
        #1;
        checkOutput("idleReq", 32'(mem_req_o), 32'd0);
        checkOutput("idleAddr", inst_addr_o, RESET_PC);
        modelPc        = RESET_PC;
        expAddr        = RESET_PC;
        tbOut          = 0;
        discardPending = 0;
    endtask

    task automatic quiesce();
        bit idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1);
            idle = (memQ.size() == 0) && !cycRsp && !inst_valid_o && (discardPending == 0);
        end
        checkOutput("quiesce", 32'(idle), 32'd1);
    endtask

    task automatic runUntilConsumed(input string tag, input int target, input int budget,
                                    input bit rdy, input bit gnt, input int lat);
        for (int i = 0; i < budget && consumed < target; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, rdy, gnt, lat);
        end
        checkOutput(tag, 32'(consumed >= target), 32'd1);
    endtask

    task automatic grantOnce(input int lat, input bit rdy);
        bit got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, rdy, 1'b1, lat);
            got = cycGrant;
        end
        checkOutput("grantOnce", 32'(got), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int g0;
        bit sawRsp;
        rst          = 1'b1;
        jump_en_i    = 1'b0;
        jump_addr_i  = 32'h0;
        hold_i       = 1'b0;
        inst_ready_i = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;

        $display("[TB] reset and sequential fetch");
        applyReset(1'b0);
        runUntilConsumed("seq3", 3, 20, 1'b1, 1'b1, 1);

        $display("[TB] backpressure fills FIFO");
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1);
        checkOutput("fullNoReq", 32'(mem_req_o), 32'd0);
        checkOutput("fullValid", 32'(inst_valid_o), 32'd1);
        c0 = consumed;
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1);
        checkOutput("drainTwo", 32'(consumed - c0), 32'd2);
        g0 = grants;
        for (int i = 0; i < 5 && grants == g0; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
        checkOutput("resume", 32'(grants > g0), 32'd1);

        $display("[TB] jump with two outstanding");
        quiesce();
        g0 = grants;
        for (int i = 0; i < 10 && grants - g0 < 2; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 6);
        checkOutput("twoOut", 32'(grants - g0), 32'd2);
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 1);
        c0 = consumed;
        runUntilConsumed("afterJump", c0 + 2, 40, 1'b1, 1'b1, 1);

        $display("[TB] jump with hold");
        quiesce();
        applyStimulus(1'b1, 32'h0000_0203, 1'b1, 1'b1, 1'b1, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1);
            checkOutput("holdAddr", inst_addr_o, 32'h0000_0200);
        end
        c0 = consumed;
        runUntilConsumed("afterHold", c0 + 1, 20, 1'b1, 1'b1, 1);

        $display("[TB] reset with one outstanding");
        quiesce();
        grantOnce(50, 1'b1);
        applyReset(1'b1);
        c0 = consumed;
        runUntilConsumed("afterReset", c0 + 1, 20, 1'b1, 1'b1, 1);

        $display("[TB] response into empty FIFO");
        quiesce();
        specialAddr = modelPc;
        grantOnce(2, 1'b0);
        sawRsp = 1'b0;
        for (int i = 0; i < 5 && !sawRsp; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1);
            sawRsp = cycRsp;
            if (sawRsp) checkOutput("bypassSame", 32'(inst_valid_o), EXP_BYPASS);
        end
        checkOutput("rspSeen", 32'(sawRsp), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("nextValid", 32'(inst_valid_o), 32'd1);
        checkOutput("nextInst", inst_o, 32'h0050_0093);
        checkOutput("nextAddr", inst_addr_o, specialAddr);
        c0 = consumed;
        runUntilConsumed("afterBypass", c0 + 1, 10, 1'b1, 1'b0, 1);

        $display("[TB] randomized traffic");
        c0 = consumed;
        for (int i = 0; i < 3000; i++) begin
            bit          rJmp;
            bit          rHold;
            bit          rRdy;
            bit          rGnt;
            logic [31:0] rAddr;
            int          rLat;
            rJmp  = ($urandom_range(0, 99) < 3);
            rAddr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom();
            rHold = ($urandom_range(0, 99) < 10);
            rRdy  = ($urandom_range(0, 99) < 70);
            rGnt  = ($urandom_range(0, 99) < 70);
            rLat  = int'($urandom_range(1, 4));
            applyStimulus(rJmp, rAddr, rHold, rRdy, rGnt, rLat);
        end
        checkOutput("randProgress", 32'(consumed - c0 > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
